// File: rtl/matmul_sched_pkg.sv
// Shared types for the matrixmul job scheduler: FSM states, job descriptor and
// completion record.
package matmul_sched_pkg;

  localparam int SCHED_ID_W  = 4;
  localparam int SCHED_ARG_W = 32;
  localparam int SCHED_CYC_W = 32;
  localparam int JOBS_DONE_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    REPORT,
    ERR
  } sched_state_e;

  typedef struct packed {
    logic [SCHED_ID_W-1:0]  id;
    logic [SCHED_ARG_W-1:0] arg;
  } job_t;

  typedef struct packed {
    logic [SCHED_ID_W-1:0]  id;
    logic [SCHED_CYC_W-1:0] cycles;
    logic                   timeout;
  } res_t;

endpackage

// File: rtl/matmul_job_scheduler_fifo.sv
// Synchronous job descriptor FIFO; full/empty come from a registered occupancy
// count, and the head entry is visible combinationally on dout.
module sched_job_fifo
  import matmul_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  job_t din,
  output job_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  job_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/matmul_job_scheduler.sv
// Job-level ap_ctrl_chain controller: queues descriptors, dispatches them in
// order, times each job with a watchdog and returns one completion record.
//
//   state  | meaning
//   IDLE   | waiting for a queued job and ap_idle
//   START  | ap_start held until the kernel returns ap_ready
//   RUN    | kernel running, waiting for ap_done
//   REPORT | completion record presented on res_*
//   ERR    | watchdog fired; sticky until reset, no further dispatch
module matmul_job_scheduler
  import matmul_sched_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ID_W    = SCHED_ID_W,
  parameter int ARG_W   = SCHED_ARG_W,
  parameter int CYC_W   = SCHED_CYC_W,
  parameter int TIMEOUT = 65536
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [ID_W-1:0]        job_id,
  input  logic [ARG_W-1:0]       job_arg,
  output logic                   ap_start,
  input  logic                   ap_ready,
  input  logic                   ap_done,
  input  logic                   ap_idle,
  output logic                   ap_continue,
  output logic [ARG_W-1:0]       kern_arg,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ID_W-1:0]        res_id,
  output logic [CYC_W-1:0]       res_cycles,
  output logic                   res_timeout,
  output logic                   busy,
  output logic [JOBS_DONE_W-1:0] jobs_done
);

  sched_state_e           state, state_nxt;
  job_t                   fifo_din, fifo_dout, cur_q;
  res_t                   res_q;
  logic [SCHED_CYC_W-1:0] cnt_q, cnt_inc, wd_q;
  logic [JOBS_DONE_W-1:0] jobs_done_q;
  logic                   fifo_full, fifo_empty, pop;
  logic                   done_hit, wd_hit, accept, wd_tc;

  assign fifo_din.id  = SCHED_ID_W'(job_id);
  assign fifo_din.arg = SCHED_ARG_W'(job_arg);
  assign job_ready    = ~fifo_full;
  assign pop          = (state == IDLE) & ~fifo_empty & ap_idle;
  assign cnt_inc      = cnt_q + SCHED_CYC_W'(1);
  // Watchdog down-counter hits zero on the TIMEOUT-th START/RUN cycle.
  assign wd_tc        = (wd_q == '0);

  sched_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (job_valid),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt   = state;
    ap_start    = 1'b0;
    ap_continue = 1'b0;
    accept      = 1'b0;
    done_hit    = 1'b0;
    wd_hit      = 1'b0;
    case (state)
      IDLE:   if (pop) state_nxt = START;
      START: begin
        ap_start = 1'b1;
        if (ap_ready && ap_done) begin
          done_hit  = 1'b1;
          state_nxt = REPORT;
        end else if (wd_tc) begin
          wd_hit    = 1'b1;
          state_nxt = REPORT;
        end else if (ap_ready) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (ap_done) begin
          done_hit  = 1'b1;
          state_nxt = REPORT;
        end else if (wd_tc) begin
          wd_hit    = 1'b1;
          state_nxt = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) begin
          accept = 1'b1;
          if (!res_q.timeout) begin
            ap_continue = 1'b1;
            state_nxt   = IDLE;
          end else begin
            state_nxt = ERR;
          end
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cur_q       <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      wd_q        <= '0;
      jobs_done_q <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        cur_q <= fifo_dout;
        cnt_q <= '0;
        wd_q  <= SCHED_CYC_W'(TIMEOUT - 1);
      end else if (state == START || state == RUN) begin
        cnt_q <= cnt_inc;
        wd_q  <= wd_q - SCHED_CYC_W'(1);
      end
      if (done_hit || wd_hit) begin
        res_q.id      <= cur_q.id;
        res_q.cycles  <= cnt_inc;
        res_q.timeout <= wd_hit;
      end
      if (accept) jobs_done_q <= jobs_done_q + JOBS_DONE_W'(1);
    end
  end

  assign kern_arg    = ARG_W'(cur_q.arg);
  assign res_valid   = (state == REPORT);
  assign res_id      = ID_W'(res_q.id);
  assign res_cycles  = CYC_W'(res_q.cycles);
  assign res_timeout = res_q.timeout;
  assign busy        = (state != IDLE);
  assign jobs_done   = jobs_done_q;

endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Directed bench for matmul_job_scheduler with a reactive kernel model and a
// queue of expected completion records.
module tb_matmul_job_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [3:0]  job_id = '0;
  logic [31:0] job_arg = '0;
  logic        ap_start;
  logic        ap_ready = 1'b0;
  logic        ap_done = 1'b0;
  logic        ap_idle = 1'b1;
  logic        ap_continue;
  logic [31:0] kern_arg;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [3:0]  res_id;
  logic [31:0] res_cycles;
  logic        res_timeout;
  logic        busy;
  logic [15:0] jobs_done;

  always #5 clock = ~clock;

  matmul_job_scheduler #(.DEPTH(4), .ID_W(4), .ARG_W(32), .CYC_W(32), .TIMEOUT(64)) dut (
    .clock(clock), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id), .job_arg(job_arg),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .ap_continue(ap_continue), .kern_arg(kern_arg),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_cycles(res_cycles), .res_timeout(res_timeout),
    .busy(busy), .jobs_done(jobs_done)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] cyc;
    logic        to;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] started[$];
  int vectors = 0;
  int errors = 0;
  int cont_pulses = 0;
  int start_hi = 0;
  int k_ready_at = 1;
  int k_done_after = 1;
  bit k_hang = 1'b0;
  int kst = 0;
  int scnt = 0;
  int dcnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Kernel model: ap_ready on the k_ready_at-th START cycle, ap_done
  // k_done_after cycles later (same cycle when 0), never when k_hang.
  always @(negedge clock) begin
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    if (!reset) begin
      kst = 0;
    end else begin
      if (kst == 0 && ap_start) begin
        kst  = 1;
        scnt = 0;
        started.push_back(kern_arg);
      end
      if (kst == 1) begin
        scnt++;
        if (scnt == k_ready_at) begin
          ap_ready = 1'b1;
          if (k_done_after == 0) begin
            ap_done = 1'b1;
            kst     = 0;
          end else begin
            kst  = 2;
            dcnt = 0;
          end
        end
      end else if (kst == 2) begin
        dcnt++;
        if (!k_hang && dcnt == k_done_after) begin
          ap_done = 1'b1;
          kst     = 0;
        end
      end
    end
  end

  always begin
    @(negedge clock);
    #1;
    if (reset) begin
      cont_pulses += int'(ap_continue);
      start_hi    += int'(ap_start);
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("res_id", res_id, e.id);
          chk("res_cycles", res_cycles, e.cyc);
          chk("res_timeout", res_timeout, e.to);
          chk("ap_continue_on_accept", ap_continue, !e.to);
        end
      end
    end
  end

  task automatic push_job(input logic [3:0] id, input logic [31:0] arg,
                          input logic [31:0] ecyc, input logic eto, input bit track);
    int n = 0;
    exp_t e;
    job_valid = 1'b1;
    job_id    = id;
    job_arg   = arg;
    while (!job_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    job_valid = 1'b0;
    if (n >= 200) begin
      chk("push_timeout", n, 0);
    end else if (track) begin
      e.id = id; e.cyc = ecyc; e.to = eto;
      sb.push_back(e);
    end
  endtask

  task automatic wait_results(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("results_drained", sb.size(), 0);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    repeat (2) @(negedge clock);
    chk("rst_job_ready", job_ready, 1);
    chk("rst_ap_start", ap_start, 0);
    chk("rst_ap_continue", ap_continue, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_jobs_done", jobs_done, 0);
    chk("rst_kern_arg", kern_arg, 0);
    chk("rst_res_cycles", res_cycles, 0);
    reset = 1'b1;
    @(negedge clock);

    // Single job: ready on 2nd START cycle, done 5 cycles later.
    k_ready_at = 2; k_done_after = 5;
    push_job(4'd3, 32'h100, 32'd7, 1'b0, 1'b1);
    wait_results(100);
    chk("t1_start_hi", start_hi, 2);
    chk("t1_started", started.size(), 1);
    chk("t1_kern_arg", started[0], 32'h100);
    chk("t1_cont", cont_pulses, 1);
    chk("t1_jobs_done", jobs_done, 1);
    chk("t1_busy", busy, 0);

    // FIFO fill with kernel not idle, then in-order dispatch.
    ap_idle = 1'b0; k_ready_at = 1; k_done_after = 1;
    for (int i = 1; i <= 4; i++) push_job(4'(i), 32'(i * 16), 32'd2, 1'b0, 1'b1);
    chk("t2_full", job_ready, 0);
    job_valid = 1'b1; job_id = 4'd5; job_arg = 32'd80;
    repeat (3) @(negedge clock);
    chk("t2_held", job_ready, 0);
    chk("t2_no_dispatch", busy, 0);
    ap_idle = 1'b1;
    n = 0;
    while (!job_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("t2_ready_returns", job_ready, 1);
    @(negedge clock);
    job_valid = 1'b0;
    sb.push_back('{id: 4'd5, cyc: 32'd2, to: 1'b0});
    wait_results(200);
    chk("t2_started", started.size(), 6);
    for (int i = 1; i <= 5; i++) chk("t2_order", started[i], 32'(i * 16));
    chk("t2_jobs_done", jobs_done, 6);
    chk("t2_start_hi", start_hi, 7);

    // Back-pressure on the result stream.
    res_ready = 1'b0; k_ready_at = 1; k_done_after = 2;
    push_job(4'd6, 32'h60, 32'd3, 1'b0, 1'b1);
    push_job(4'd8, 32'h80, 32'd3, 1'b0, 1'b1);
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("t3_report", res_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("t3_valid", res_valid, 1);
      chk("t3_id", res_id, 4'd6);
      chk("t3_cycles", res_cycles, 32'd3);
      chk("t3_cont", ap_continue, 0);
      chk("t3_jobs_done", jobs_done, 6);
    end
    chk("t3_no_start", start_hi, 8);
    res_ready = 1'b1;
    wait_results(100);
    chk("t3_jobs_done_after", jobs_done, 8);
    chk("t3_cont_total", cont_pulses, 8);

    // ap_ready and ap_done on the first START cycle.
    k_ready_at = 1; k_done_after = 0;
    push_job(4'd10, 32'hA0, 32'd1, 1'b0, 1'b1);
    wait_results(100);
    chk("t5_start_hi", start_hi, 10);
    chk("t5_jobs_done", jobs_done, 9);

    // Watchdog: ap_done never arrives.
    k_hang = 1'b1; k_ready_at = 1; k_done_after = 1;
    push_job(4'd9, 32'h90, 32'd64, 1'b1, 1'b1);
    push_job(4'd11, 32'hB0, 32'd0, 1'b0, 1'b0);
    push_job(4'd12, 32'hC0, 32'd0, 1'b0, 1'b0);
    wait_results(300);
    repeat (5) @(negedge clock);
    chk("t4_busy", busy, 1);
    chk("t4_res_valid", res_valid, 0);
    chk("t4_ap_start", ap_start, 0);
    chk("t4_started", started.size(), 10);
    chk("t4_cont", cont_pulses, 9);
    chk("t4_jobs_done", jobs_done, 10);
    chk("t4_job_ready", job_ready, 1);

    // Reset mid-RUN with two jobs queued.
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    k_hang = 1'b0; k_ready_at = 1; k_done_after = 30;
    push_job(4'd13, 32'hD0, 32'd0, 1'b0, 1'b0);
    push_job(4'd14, 32'hE0, 32'd0, 1'b0, 1'b0);
    push_job(4'd15, 32'hF0, 32'd0, 1'b0, 1'b0);
    n = 0;
    while (kst != 2 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("t6_in_run", busy, 1);
    reset = 1'b0;
    #1;
    chk("t6_rst_ap_start", ap_start, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_res_valid", res_valid, 0);
    chk("t6_rst_jobs_done", jobs_done, 0);
    chk("t6_rst_kern_arg", kern_arg, 0);
    chk("t6_rst_job_ready", job_ready, 1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    chk("t6_fifo_empty", busy, 0);
    chk("t6_started", started.size(), 11);
    k_done_after = 2;
    push_job(4'd7, 32'h70, 32'd3, 1'b0, 1'b1);
    wait_results(100);
    chk("t6_jobs_done", jobs_done, 1);
    chk("t6_started_after", started.size(), 12);
    chk("t6_kern_arg", started[11], 32'h70);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
